// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : fft_pkg                                                   |
// | Purpose  : Shared FFT sizing constants, reader state encoding and    |
// |            the bit-reversal helper used by the reorder buffer.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int c_N     = 32;  // FFT points per frame
  localparam int c_LOG2N = 5;   // log2(c_N), width of index/counter fields
  localparam int c_W     = 19;  // width of each real / imaginary sample

  // Reader FSM encoding
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverse the low nbits bits of x; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int nbits);
    logic [31:0] rev;
    for (int b = 0; b < 32; b++) begin
      rev[b] = x[31-b];
    end
    return rev >> (32 - nbits);
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_reorder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_reorder_bank                                          |
// | Purpose  : Ping/pong sample store, 2 banks x N entries x 2W bits,    |
// |            one write port and one registered read port.              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int N     = c_N,
  parameter int LOG2N = c_LOG2N,
  parameter int W     = c_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [2*W-1:0]   wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [2*W-1:0]   rd_data
);

  // Bank select is the top address bit, so both banks share one array.
  logic [2*W-1:0] r_mem [0:2*N-1];
  logic [2*W-1:0] r_rd_data;

  // Write port: memory contents are never reset, only overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Registered read port; cleared by reset so the outputs start at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[{rd_bank, rd_addr}];
    end
  end

  assign rd_data = r_rd_data;

endmodule : fft_reorder_bank
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_reorder                                               |
// | Purpose  : Converts bit-reversed FFT output into natural order using |
// |            a ping/pong buffer: writer scatters at bitrev(wr_cnt),    |
// |            reader drains the full bank sequentially.                 |
// | Option   : FFT_REORDER_SOF_EN adds in_sof to realign a frame.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fft_reorder
  import fft_pkg::*;
#(
  parameter int N     = c_N,
  parameter int LOG2N = c_LOG2N,
  parameter int W     = c_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_r,
  input  logic [W-1:0]     in_i,
`ifdef FFT_REORDER_SOF_EN
  input  logic             in_sof,
`endif
  output logic             out_valid,
  output logic [W-1:0]     out_r,
  output logic [W-1:0]     out_i,
  output logic [LOG2N-1:0] out_idx
);

  localparam logic [LOG2N-1:0] c_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] c_ONE  = LOG2N'(1);

  // Write side state
  logic [LOG2N-1:0] r_wr_cnt;
  logic             r_wr_bank;
  logic             r_full_pend;   // a filled bank is waiting for the reader
  logic             r_full_bank;   // which bank that is

  // Read side state
  rd_state_t        r_state;
  logic [LOG2N-1:0] r_rd_cnt;
  logic             r_rd_bank;
  logic             r_out_valid;
  logic [LOG2N-1:0] r_out_idx;

  logic             w_sof;
  logic [LOG2N-1:0] w_wr_addr;
  logic             w_last_wr;
  logic             w_take;
  logic             w_rd_en;
  logic [2*W-1:0]   w_rd_data;

`ifdef FFT_REORDER_SOF_EN
  assign w_sof = in_valid & in_sof;
`else
  assign w_sof = 1'b0;
`endif

  // A start-of-frame sample always lands at bitrev(0) = 0.
  assign w_wr_addr = w_sof ? '0 : LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));
  assign w_last_wr = in_valid & ~w_sof & (r_wr_cnt == c_LAST);

  // Reader consumes the pending bank when idle or on its final read.
  assign w_take  = r_full_pend & ((r_state == RD_IDLE) | (r_rd_cnt == c_LAST));
  assign w_rd_en = (r_state == RD_READ);

  // Writer: scatter samples, flip banks and flag the filled one at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_full_pend <= 1'b0;
      r_full_bank <= 1'b0;
    end else begin
      if (in_valid) begin
        r_wr_cnt <= w_sof ? c_ONE : r_wr_cnt + c_ONE;
      end
      if (w_last_wr) begin
        r_wr_bank   <= ~r_wr_bank;
        r_full_bank <= r_wr_bank;
        r_full_pend <= 1'b1;
      end else if (w_take) begin
        r_full_pend <= 1'b0;
      end
    end
  end

  // Reader FSM: sweep 0..N-1 gap-free, chaining straight into a waiting bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RD_IDLE;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      r_out_valid <= (r_state == RD_READ);
      r_out_idx   <= r_rd_cnt;
      case (r_state)
        RD_IDLE: begin
          if (r_full_pend) begin
            r_state   <= RD_READ;
            r_rd_cnt  <= '0;
            r_rd_bank <= r_full_bank;
          end
        end
        RD_READ: begin
          if (r_rd_cnt == c_LAST) begin
            r_rd_cnt <= '0;
            if (r_full_pend) begin
              r_rd_bank <= r_full_bank;
            end else begin
              r_state <= RD_IDLE;
            end
          end else begin
            r_rd_cnt <= r_rd_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= RD_IDLE;
        end
      endcase
    end
  end

  fft_reorder_bank #(
    .N     (N),
    .LOG2N (LOG2N),
    .W     (W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_bank (r_wr_bank),
    .wr_addr (w_wr_addr),
    .wr_data ({in_r, in_i}),
    .rd_en   (w_rd_en),
    .rd_bank (r_rd_bank),
    .rd_addr (r_rd_cnt),
    .rd_data (w_rd_data)
  );

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_r     = w_rd_data[2*W-1:W];
  assign out_i     = w_rd_data[W-1:0];

endmodule : fft_reorder
`default_nettype wire
